// File: rtl/scr1_dmi_hs.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_dmi_hs
//  Description : Debug Module Interface with a full request/response
//                handshake toward the Debug Module. Serves the DTMCS and
//                DMI_ACCESS TAP data registers, holds each DM request until
//                the DM answers, and tracks sticky busy/failed status.
//  Revision    : 1.0 - initial release
// ============================================================================
module scr1_dmi_hs #(
    parameter int unsigned ABITS     = 7,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CH_ID_W   = 2,
    parameter int unsigned DTMCS_ID  = 1,
    parameter int unsigned DMI_ID    = 2,
    parameter int unsigned IDLE_HINT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    // TAP chain side
    input  logic               ch_sel_i,
    input  logic [CH_ID_W-1:0] ch_id_i,
    input  logic               ch_capture_i,
    input  logic               ch_shift_i,
    input  logic               ch_update_i,
    input  logic               ch_tdi_i,
    output logic               ch_tdo_o,
    // Debug Module side
    output logic               dm_req_o,
    output logic               dm_wr_o,
    output logic [ABITS-1:0]   dm_addr_o,
    output logic [DATA_W-1:0]  dm_wdata_o,
    input  logic               dm_resp_i,
    input  logic               dm_err_i,
    input  logic [DATA_W-1:0]  dm_rdata_i
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned        c_DRW      = ABITS + DATA_W + 2;
    localparam logic [CH_ID_W-1:0] c_DTMCS_CH = CH_ID_W'(DTMCS_ID);
    localparam logic [CH_ID_W-1:0] c_DMI_CH   = CH_ID_W'(DMI_ID);

    localparam logic [1:0] c_OP_NOP = 2'd0;
    localparam logic [1:0] c_OP_RD  = 2'd1;
    localparam logic [1:0] c_OP_WR  = 2'd2;
    localparam logic [1:0] c_OP_RSV = 2'd3;

    localparam logic [1:0] c_STAT_OK   = 2'd0;
    localparam logic [1:0] c_STAT_FAIL = 2'd2;
    localparam logic [1:0] c_STAT_BUSY = 2'd3;

    localparam logic [2:0] c_IDLE_HINT = 3'(IDLE_HINT);
    localparam logic [5:0] c_ABITS_FLD = 6'(ABITS);
    localparam logic [3:0] c_VERSION   = 4'd1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [c_DRW-1:0]    r_tap_dr;
    logic [1:0]          r_sticky;
    logic [ABITS-1:0]    r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wr;
    logic [DATA_W-1:0]   r_rdata;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_resp_done;
    logic [1:0]          w_sticky_nxt;

    logic                w_dtmcs_sel;
    logic                w_dmi_sel;
    logic                w_dtmcs_upd;
    logic                w_dmi_upd;
    logic                w_dmireset;
    logic                w_hardreset;
    logic                w_busy_err;
    logic                w_rsv_op;

    logic [1:0]          w_upd_op;
    logic [DATA_W-1:0]   w_upd_data;
    logic [ABITS-1:0]    w_upd_addr;

    logic [1:0]          w_opstat;
    logic [31:0]         w_dtmcs_cap;
    logic [c_DRW-1:0]    w_dmi_cap;
    logic [31:0]         w_dtmcs_shift;

    // Chain decode: a register is addressed only while its chain is selected
    assign w_dtmcs_sel = ch_sel_i & (ch_id_i == c_DTMCS_CH);
    assign w_dmi_sel   = ch_sel_i & (ch_id_i == c_DMI_CH);
    assign w_dtmcs_upd = ch_update_i & w_dtmcs_sel;
    assign w_dmi_upd   = ch_update_i & w_dmi_sel;

    // DTMCS control bits as shifted in by the debugger
    assign w_dmireset  = w_dtmcs_upd & r_tap_dr[16];
    assign w_hardreset = w_dtmcs_upd & r_tap_dr[17];

    // DMI_ACCESS fields, layout {addr, data, op}
    assign w_upd_op   = r_tap_dr[1:0];
    assign w_upd_data = r_tap_dr[DATA_W+1:2];
    assign w_upd_addr = r_tap_dr[c_DRW-1:DATA_W+2];

    // A DMI access arriving while a request is outstanding is a busy error;
    // a reserved op arriving in idle is a failure
    assign w_busy_err = w_dmi_upd & (r_state == ST_BUSY);
    assign w_rsv_op   = w_dmi_upd & (r_state == ST_IDLE) & (w_upd_op == c_OP_RSV);

    // Capture images of both data registers
    assign w_opstat    = (r_state == ST_BUSY) ? c_STAT_BUSY : r_sticky;
    assign w_dtmcs_cap = {14'b0, 2'b0, 1'b0, c_IDLE_HINT, r_sticky, c_ABITS_FLD, c_VERSION};
    assign w_dmi_cap   = {r_addr, r_rdata, w_opstat};

    // DTMCS is only 32 bits long: TDI enters at bit 31 and the rest stays zero
    assign w_dtmcs_shift = {ch_tdi_i, r_tap_dr[31:1]};

    // Request outputs come straight from flops
    assign ch_tdo_o   = r_tap_dr[0];
    assign dm_req_o   = (r_state == ST_BUSY);
    assign dm_wr_o    = r_wr;
    assign dm_addr_o  = r_addr;
    assign dm_wdata_o = r_wdata;

    // Handshake state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept a read/write in idle, finish on DM response
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_resp_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_dmi_upd && (r_sticky == c_STAT_OK) &&
                    ((w_upd_op == c_OP_RD) || (w_upd_op == c_OP_WR))) begin
                    w_state_nxt = ST_BUSY;
                    w_accept    = 1'b1;
                end
            end
            ST_BUSY: begin
                if (dm_resp_i) begin
                    w_state_nxt = ST_IDLE;
                    w_resp_done = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Hard reset abandons the transaction, including a same-cycle response
        if (w_hardreset) begin
            w_state_nxt = ST_IDLE;
            w_accept    = 1'b0;
            w_resp_done = 1'b0;
        end
    end

    // Sticky status: cleared by either reset bit, otherwise set only from OK
    always_comb begin
        w_sticky_nxt = r_sticky;
        if (w_dmireset || w_hardreset) begin
            w_sticky_nxt = c_STAT_OK;
        end else if (r_sticky == c_STAT_OK) begin
            if (w_busy_err) begin
                w_sticky_nxt = c_STAT_BUSY;
            end else if (w_resp_done && dm_err_i) begin
                w_sticky_nxt = c_STAT_FAIL;
            end else if (w_rsv_op) begin
                w_sticky_nxt = c_STAT_FAIL;
            end
        end
    end

    // Sticky status register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= c_STAT_OK;
        end else begin
            r_sticky <= w_sticky_nxt;
        end
    end

    // Request fields are latched on acceptance and held while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= w_upd_addr;
            r_wdata <= w_upd_data;
            r_wr    <= (w_upd_op == c_OP_WR);
        end
    end

    // Read data is kept only from a successful read response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_resp_done && !r_wr && !dm_err_i) begin
            r_rdata <= dm_rdata_i;
        end
    end

    // TAP data register: capture wins over shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap_dr <= '0;
        end else if (ch_capture_i && w_dtmcs_sel) begin
            r_tap_dr <= c_DRW'(w_dtmcs_cap);
        end else if (ch_capture_i && w_dmi_sel) begin
            r_tap_dr <= w_dmi_cap;
        end else if (ch_shift_i && w_dtmcs_sel) begin
            r_tap_dr <= c_DRW'(w_dtmcs_shift);
        end else if (ch_shift_i && w_dmi_sel) begin
            r_tap_dr <= {ch_tdi_i, r_tap_dr[c_DRW-1:1]};
        end
    end

    // Nop is accepted by the debugger protocol and produces no activity
    logic w_unused_nop;
    assign w_unused_nop = (w_upd_op == c_OP_NOP);

endmodule
`default_nettype wire

// File: tb/tb_scr1_dmi_hs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scr1_dmi_hs
//  Description : Self-checking bench for scr1_dmi_hs. A table of DMI
//                transactions against an auto-responding DM model, followed
//                by hand-written busy, hard-reset and async-reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scr1_dmi_hs;

    localparam logic [1:0] c_DTMCS_CH = 2'd1;
    localparam logic [1:0] c_DMI_CH   = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        ch_sel_i;
    logic [1:0]  ch_id_i;
    logic        ch_capture_i;
    logic        ch_shift_i;
    logic        ch_update_i;
    logic        ch_tdi_i;
    logic        ch_tdo_o;
    logic        dm_req_o;
    logic        dm_wr_o;
    logic [6:0]  dm_addr_o;
    logic [31:0] dm_wdata_o;
    logic        dm_resp_i;
    logic        dm_err_i;
    logic [31:0] dm_rdata_i;

    // DM model controls: automatic responder or manual pulses from the test
    logic        dm_auto;
    int          dm_dly;
    logic        auto_resp, auto_err, man_resp, man_err;
    logic [31:0] auto_rdata, man_rdata, cfg_rsp;
    logic        cfg_err;

    assign dm_resp_i  = auto_resp | man_resp;
    assign dm_err_i   = dm_auto ? auto_err   : man_err;
    assign dm_rdata_i = dm_auto ? auto_rdata : man_rdata;

    // Request monitor
    int          req_cyc;
    int          unstable_cnt;
    logic        prev_req;
    logic        snap_wr;
    logic [6:0]  snap_addr;
    logic [31:0] snap_wdata;

    int n_tests;
    int n_fail;

    scr1_dmi_hs dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_sel_i     (ch_sel_i),
        .ch_id_i      (ch_id_i),
        .ch_capture_i (ch_capture_i),
        .ch_shift_i   (ch_shift_i),
        .ch_update_i  (ch_update_i),
        .ch_tdi_i     (ch_tdi_i),
        .ch_tdo_o     (ch_tdo_o),
        .dm_req_o     (dm_req_o),
        .dm_wr_o      (dm_wr_o),
        .dm_addr_o    (dm_addr_o),
        .dm_wdata_o   (dm_wdata_o),
        .dm_resp_i    (dm_resp_i),
        .dm_err_i     (dm_err_i),
        .dm_rdata_i   (dm_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Auto DM: answer dm_dly cycles after the request is first seen
    initial begin
        int age;
        age        = 0;
        auto_resp  = 1'b0;
        auto_err   = 1'b0;
        auto_rdata = '0;
        forever begin
            @(negedge clk);
            auto_resp = 1'b0;
            if (dm_auto && dm_req_o) begin
                age = age + 1;
                if (age == dm_dly + 1) begin
                    auto_resp  = 1'b1;
                    auto_err   = cfg_err;
                    auto_rdata = cfg_rsp;
                end
            end else begin
                age = 0;
            end
        end
    end

    // Count request cycles and flag any change of the request fields
    initial begin
        req_cyc      = 0;
        unstable_cnt = 0;
        prev_req     = 1'b0;
        snap_wr      = 1'b0;
        snap_addr    = '0;
        snap_wdata   = '0;
        forever begin
            @(negedge clk);
            if (dm_req_o) begin
                if (!prev_req) begin
                    snap_wr    = dm_wr_o;
                    snap_addr  = dm_addr_o;
                    snap_wdata = dm_wdata_o;
                end else if ({dm_wr_o, dm_addr_o, dm_wdata_o} !== {snap_wr, snap_addr, snap_wdata}) begin
                    unstable_cnt = unstable_cnt + 1;
                end
                req_cyc = req_cyc + 1;
            end
            prev_req = dm_req_o;
        end
    end

    function automatic logic [40:0] mk(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {a, d, op};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Capture, shift len bits (tdo collected LSB first), optional update.
    // rsp_upd fires a DM response in the same cycle as the update.
    task automatic scan(input logic [1:0] id, input logic [40:0] din, input int len,
                        input bit upd, input bit rsp_upd, input logic rerr,
                        input logic [31:0] rdat, output logic [40:0] dout);
        dout         = '0;
        ch_sel_i     = 1'b1;
        ch_id_i      = id;
        ch_capture_i = 1'b1;
        @(negedge clk);
        ch_capture_i = 1'b0;
        ch_shift_i   = 1'b1;
        for (int i = 0; i < len; i++) begin
            dout[i]  = ch_tdo_o;
            ch_tdi_i = din[i];
            @(negedge clk);
        end
        ch_shift_i = 1'b0;
        ch_tdi_i   = 1'b0;
        if (upd) begin
            ch_update_i = 1'b1;
            if (rsp_upd) begin
                man_resp  = 1'b1;
                man_err   = rerr;
                man_rdata = rdat;
            end
            @(negedge clk);
            ch_update_i = 1'b0;
            man_resp    = 1'b0;
        end
        ch_sel_i = 1'b0;
    endtask

    task automatic dmi_scan(input logic [40:0] din, input bit upd, output logic [40:0] dout);
        scan(c_DMI_CH, din, 41, upd, 1'b0, 1'b0, 32'h0, dout);
    endtask

    task automatic dtmcs_scan(input logic [31:0] din, input bit upd, output logic [40:0] dout);
        scan(c_DTMCS_CH, {9'b0, din}, 32, upd, 1'b0, 1'b0, 32'h0, dout);
    endtask

    task automatic dm_pulse(input logic err, input logic [31:0] d);
        man_err   = err;
        man_rdata = d;
        man_resp  = 1'b1;
        @(negedge clk);
        man_resp  = 1'b0;
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
        int          dly;
        logic        err;
        logic [31:0] rsp;
        int          req;     // expected request cycles
        logic [40:0] cap;     // expected DMI capture afterwards
        logic [31:0] dtmcs;   // expected DTMCS capture afterwards
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [40:0] d;
        int          base_req;
        int          base_uns;

        tbl[0] = '{7'h10, 32'hDEADBEEF, 2'd2, 3, 1'b0, 32'h0,        4, mk(7'h10, 32'h0,        2'd0), 32'h0000_1071};
        tbl[1] = '{7'h04, 32'h0,        2'd1, 0, 1'b0, 32'h12345678, 1, mk(7'h04, 32'h12345678, 2'd0), 32'h0000_1071};
        tbl[2] = '{7'h05, 32'h0,        2'd1, 1, 1'b1, 32'hFFFFFFFF, 2, mk(7'h05, 32'h12345678, 2'd2), 32'h0000_1871};
        tbl[3] = '{7'h22, 32'h55,       2'd3, 0, 1'b0, 32'h0,        0, mk(7'h05, 32'h12345678, 2'd2), 32'h0000_1871};
        tbl[4] = '{7'h33, 32'h0,        2'd0, 0, 1'b0, 32'h0,        0, mk(7'h05, 32'h12345678, 2'd0), 32'h0000_1071};
        tbl[5] = '{7'h7F, 32'h0,        2'd1, 2, 1'b0, 32'hA5A50F0F, 3, mk(7'h7F, 32'hA5A50F0F, 2'd0), 32'h0000_1071};
        tbl[6] = '{7'h01, 32'h0,        2'd2, 0, 1'b0, 32'h0,        1, mk(7'h01, 32'hA5A50F0F, 2'd0), 32'h0000_1071};

        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        ch_sel_i     = 1'b0;
        ch_id_i      = '0;
        ch_capture_i = 1'b0;
        ch_shift_i   = 1'b0;
        ch_update_i  = 1'b0;
        ch_tdi_i     = 1'b0;
        dm_auto      = 1'b0;
        dm_dly       = 0;
        cfg_err      = 1'b0;
        cfg_rsp      = '0;
        man_resp     = 1'b0;
        man_err      = 1'b0;
        man_rdata    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req",   {31'b0, dm_req_o, dm_wr_o, ch_tdo_o}, 64'h0);
        check("rst_addr",  dm_addr_o, 64'h0);
        check("rst_wdata", dm_wdata_o, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        dtmcs_scan(32'h0, 1'b0, d);
        check("rst_dtmcs", d, 64'h1071);
        dmi_scan(41'h0, 1'b0, d);
        check("rst_dmi_cap", d, 64'h0);

        // Table-driven transactions against the auto-responding DM
        for (int i = 0; i < 7; i++) begin
            dm_auto  = 1'b1;
            dm_dly   = tbl[i].dly;
            cfg_err  = tbl[i].err;
            cfg_rsp  = tbl[i].rsp;
            base_req = req_cyc;
            base_uns = unstable_cnt;
            dmi_scan(mk(tbl[i].addr, tbl[i].data, tbl[i].op), 1'b1, d);
            repeat (8) @(negedge clk);
            check($sformatf("row%0d_req_cycles", i), 64'(req_cyc - base_req), 64'(tbl[i].req));
            if (tbl[i].req != 0) begin
                check($sformatf("row%0d_wr", i), {63'b0, snap_wr}, {63'b0, tbl[i].op == 2'd2});
                check($sformatf("row%0d_addr", i), snap_addr, tbl[i].addr);
                check($sformatf("row%0d_wdata", i), snap_wdata, tbl[i].data);
                check($sformatf("row%0d_stable", i), 64'(unstable_cnt - base_uns), 64'h0);
            end
            dmi_scan(41'h0, 1'b0, d);
            check($sformatf("row%0d_dmi_cap", i), d, tbl[i].cap);
            dtmcs_scan(32'h0001_0000, 1'b1, d);
            check($sformatf("row%0d_dtmcs", i), d, tbl[i].dtmcs);
        end
        dm_auto = 1'b0;
        @(negedge clk);

        // Busy error while the DM stalls, then dmireset
        dmi_scan(mk(7'h11, 32'h0, 2'd1), 1'b1, d);
        check("A_req_on", dm_req_o, 64'h1);
        dmi_scan(mk(7'h12, 32'h0, 2'd1), 1'b1, d);
        check("A_busy_cap", d, mk(7'h11, 32'hA5A50F0F, 2'd3));
        check("A_hold", {dm_req_o, dm_addr_o}, {1'b1, 7'h11});
        dm_pulse(1'b0, 32'hCAFEF00D);
        check("A_req_off", dm_req_o, 64'h0);
        dmi_scan(41'h0, 1'b0, d);
        check("A_cap_after", d, mk(7'h11, 32'hCAFEF00D, 2'd3));
        dtmcs_scan(32'h0, 1'b0, d);
        check("A_dmistat3", d, 64'h1C71);
        base_req = req_cyc;
        dmi_scan(mk(7'h13, 32'h0, 2'd1), 1'b1, d);
        repeat (3) @(negedge clk);
        check("A_ignored", 64'(req_cyc - base_req), 64'h0);
        dtmcs_scan(32'h0001_0000, 1'b1, d);
        check("A_reset_cap", d, 64'h1C71);
        dmi_scan(mk(7'h14, 32'h0, 2'd1), 1'b1, d);
        check("A_accept", {dm_req_o, dm_addr_o}, {1'b1, 7'h14});
        dm_pulse(1'b0, 32'h14141414);

        // dmihardreset with an erroring response in the same cycle
        dmi_scan(mk(7'h20, 32'h0, 2'd1), 1'b1, d);
        dmi_scan(mk(7'h21, 32'h0, 2'd1), 1'b1, d);
        scan(c_DTMCS_CH, 41'h0_0002_0000, 32, 1'b1, 1'b1, 1'b1, 32'hBAD0BAD0, d);
        check("B_req_off", dm_req_o, 64'h0);
        dmi_scan(41'h0, 1'b0, d);
        check("B_rdata_kept", d, mk(7'h20, 32'h14141414, 2'd0));
        dtmcs_scan(32'h0, 1'b0, d);
        check("B_dmistat0", d, 64'h1071);

        // dmihardreset alone drops the request on the next edge
        dmi_scan(mk(7'h22, 32'h0, 2'd1), 1'b1, d);
        check("B2_req_on", dm_req_o, 64'h1);
        dtmcs_scan(32'h0002_0000, 1'b1, d);
        check("B2_req_off", dm_req_o, 64'h0);

        // Response error and busy error in the same cycle: busy wins
        dmi_scan(mk(7'h30, 32'h0, 2'd1), 1'b1, d);
        scan(c_DMI_CH, mk(7'h31, 32'h0, 2'd2), 41, 1'b1, 1'b1, 1'b1, 32'h30303030, d);
        check("C_req_off", dm_req_o, 64'h0);
        dmi_scan(41'h0, 1'b0, d);
        check("C_cap", d, mk(7'h30, 32'h14141414, 2'd3));
        dtmcs_scan(32'h0001_0000, 1'b1, d);
        check("C_stat3", d, 64'h1C71);
        dmi_scan(mk(7'h32, 32'h0, 2'd1), 1'b1, d);
        check("C_accept", {dm_req_o, dm_addr_o}, {1'b1, 7'h32});
        dm_pulse(1'b0, 32'h32323232);

        // Asynchronous reset in the middle of a busy write
        dmi_scan(mk(7'h2A, 32'h600DF00D, 2'd2), 1'b1, d);
        check("D_req_on", {dm_req_o, dm_wr_o, dm_addr_o, dm_wdata_o}, {1'b1, 1'b1, 7'h2A, 32'h600DF00D});
        #2 rst_n = 1'b0;
        #1;
        check("D_async_rst", {dm_req_o, dm_wr_o, dm_addr_o, dm_wdata_o, ch_tdo_o}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scr1_dmi_hs.md
Name: scr1_dmi_hs

Overview:
Parametrised Debug Module Interface with a full request/response handshake toward the Debug Module (DM). It sits between the synchronised TAP controller chain interface and the DM, and serves two TAP data registers: DTMCS and DMI_ACCESS. Unlike the single-cycle DMI, a DM request is held until the DM responds, and the block reports busy and failed status in the DTMCS dmistat field and the DMI op field. It also implements dmireset and dmihardreset.

Parameters:
ABITS, 7, DMI address width; reported in DTMCS.abits.
DATA_W, 32, DMI data width.
CH_ID_W, 2, TAP chain-ID width.
DTMCS_ID, 1, chain ID of DTMCS.
DMI_ID, 2, chain ID of DMI_ACCESS.
IDLE_HINT, 1, value reported in DTMCS.idle (3 bits).

Ports:
clk  in  1  clock
rst_n  in  1  reset
ch_sel_i  in  1  chain select
ch_id_i  in  CH_ID_W  chain ID
ch_capture_i  in  1  capture-DR strobe
ch_shift_i  in  1  shift-DR strobe
ch_update_i  in  1  update-DR strobe
ch_tdi_i  in  1  serial data in
ch_tdo_o  out  1  serial data out, equal to tap_dr[0]
dm_req_o  out  1  DM request, held until dm_resp_i
dm_wr_o  out  1  1 = write, 0 = read
dm_addr_o  out  ABITS  DM address
dm_wdata_o  out  DATA_W  DM write data
dm_resp_i  in  1  DM response, one-cycle pulse
dm_err_i  in  1  response failed; sampled with dm_resp_i
dm_rdata_i  in  DATA_W  read data; sampled with dm_resp_i

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. At reset all outputs are 0, tap_dr = 0, rdata_ff = 0, addr_ff = 0, sticky = 0, state = IDLE.
- DR width: DRW = ABITS + DATA_W + 2. DMI layout is {addr, data, op}. DTMCS occupies bits [31:0].
- Capture (ch_capture_i):
  - DTMCS: {14'b0, 2'b0, 1'b0, IDLE_HINT[2:0], dmistat, ABITS[5:0], 4'd1}, where dmistat = sticky.
  - DMI: {addr_ff, rdata_ff, opstat}, where opstat = 2'd3 if state == BUSY, else sticky.
- Shift (ch_shift_i):
  - DTMCS: 32-bit right shift; tdi enters bit 31; upper bits are forced to 0.
  - DMI: DRW-bit right shift; tdi enters bit DRW-1.
  - Capture has priority over shift.
- Sticky status (2 bits): 0 = ok, 2 = failed, 3 = busy. It is updated only from 0; a nonzero value is not overwritten by another error.
- FSM, two states, IDLE and BUSY:
  - IDLE -> BUSY on update & sel & id == DMI_ID & sticky == 0 & op ∈ {1 read, 2 write}.
    - Latch addr_ff, wdata, wr.
    - dm_req_o rises on the next cycle; request outputs are registered.
  - op = 0 (nop): no action. op = 3 (reserved): sticky <= 2, no request.
  - DMI update with sticky != 0: ignored; no request, sticky unchanged.
  - BUSY: dm_req_o, dm_wr_o, dm_addr_o and dm_wdata_o are held stable.
  - BUSY -> IDLE on dm_resp_i:
    - dm_req_o drops in the same clock edge.
    - A read with dm_err_i = 0 loads rdata_ff <= dm_rdata_i.
    - dm_err_i = 1 sets sticky <= 2; rdata_ff is unchanged.
  - DMI update while BUSY: sticky <= 3; the in-flight request continues unaffected.
  - dm_resp_i in IDLE is ignored.
- DTMCS update (update & sel & id == DTMCS_ID):
  - bit16 (dmireset): sticky <= 0; an in-flight request continues.
  - bit17 (dmihardreset): sticky <= 0, state <= IDLE, dm_req_o <= 0 on the next edge.
    - A dm_resp_i in the same cycle is discarded: no rdata_ff load, no error.
- Simultaneous events:
  - dm_resp_i and a DMI update in the same BUSY cycle: the response completes and the update is a busy error (sticky <= 3 if previously 0).
  - Response error and busy error in the same cycle: busy (3) wins.
- Minimum latency: DMI update to dm_req_o = 1 cycle. dm_resp_i to a new request being accepted = 1 cycle.

Test Plan:
- Reset, then capture DTMCS and shift out 32 bits (ABITS = 7) -> 0x0000_1071 (idle = 1, abits = 7, version = 1).
- DMI write: addr 0x10, data 0xDEADBEEF, op 2. DM responds after 3 cycles -> dm_req_o high for exactly 4 cycles with wr = 1, addr 0x10, wdata 0xDEADBEEF. Next DMI capture op = 0.
- DMI read of addr 0x04, DM returns 0x12345678 -> the following DMI capture shifts out {0x04, 0x12345678, 2'b00}.
- Second DMI update while the DM stalls -> capture op = 3 during BUSY. After the response, op = 3 and DTMCS dmistat = 3. A further read is ignored (no dm_req_o). DTMCS write with bit16 = 1 -> dmistat = 0 and the read is accepted.
- Read with dm_err_i = 1 -> dmistat = 2 and rdata_ff keeps its prior value. Reserved op = 3 -> dmistat = 2 with no request.
- dmihardreset while BUSY, with dm_resp_i in the same cycle -> dm_req_o low next cycle, rdata_ff unchanged, dmistat = 0. Asserting rst_n mid-BUSY -> all outputs 0 immediately.
